// File: rtl/kv_pkg.sv
// Shared widths and state type for the key/value store blocks.
package kv_pkg;

    localparam int unsigned KV_KEY_SIZE   = 64;
    localparam int unsigned KV_VALUE_SIZE = 32;
    localparam int unsigned KV_ADDR_WIDTH = 4;
    localparam int unsigned KV_USER_WIDTH = 4;

    typedef enum logic {INIT, RUN} kv_ram_state_t;

endpackage

// File: rtl/kv_resp_fifo.sv
// Synchronous response FIFO; head is shown combinationally, count feeds the credit check.
module kv_resp_fifo
    import kv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = KV_VALUE_SIZE + KV_USER_WIDTH,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_en     = pop & (count_q != '0);
    assign head_data  = mem[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

    // Caller guarantees push never lands on a full buffer unless a pop is in the same cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/kv_value_ram.sv
// Per-slot value store behind the CAM: cleared after reset, 2-cycle read latency,
// write-first on same-cycle collisions, credit-limited response buffer.
module kv_value_ram
    import kv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = KV_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = KV_VALUE_SIZE,
    parameter int unsigned USER_WIDTH = KV_USER_WIDTH,
    parameter int unsigned OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic                  s_write_valid,
    output logic                  s_write_ready,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    input  logic [USER_WIDTH-1:0] s_read_user,
    input  logic                  s_read_valid,
    output logic                  s_read_ready,
    output logic [DATA_WIDTH-1:0] m_read_data,
    output logic                  m_read_valid,
    output logic [USER_WIDTH-1:0] m_read_user,
    input  logic                  m_read_ready,
    output logic                  init_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = $clog2(OUT_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    kv_ram_state_t state_q, state_d;
    logic [ADDR_WIDTH:0] init_cnt_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_data_q, byp_data_q;
    logic [USER_WIDTH-1:0] rd_user_q;
    logic                  rd_valid_q, byp_q;

    logic [DATA_WIDTH+USER_WIDTH-1:0] head_data;
    logic                             head_valid;
    logic [CW-1:0]                    fifo_count;
    logic [CW-1:0]                    credit;

    assign wr_acc = s_write_valid & s_write_ready;
    assign rd_acc = s_read_valid & s_read_ready;
    assign credit = fifo_count + CW'(rd_valid_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_cnt_q <= init_cnt_q + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT: if (init_cnt_q == LAST_SLOT) state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    always_comb begin
        s_write_ready = !rst && (state_q == RUN);
        s_read_ready  = !rst && (state_q == RUN) && (credit < CW'(OUT_DEPTH));
        init_busy     = rst || (state_q == INIT);
        mem_we        = (!rst && (state_q == INIT)) || wr_acc;
        mem_waddr     = (state_q == INIT) ? init_cnt_q[ADDR_WIDTH-1:0] : s_write_addr;
        mem_wdata     = (state_q == INIT) ? '0 : s_write_data;
        m_read_valid  = !rst && head_valid;
        m_read_data   = rst ? '0 : head_data[DATA_WIDTH-1:0];
        m_read_user   = rst ? '0 : head_data[DATA_WIDTH+USER_WIDTH-1:DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Array read is read-before-write, so a same-cycle write to the read slot goes via byp_data_q.
    always_ff @(posedge clk) begin
        if (rd_acc) begin
            rd_data_q  <= mem[s_read_addr];
            byp_data_q <= s_write_data;
            rd_user_q  <= s_read_user;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            byp_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            byp_q      <= rd_acc && wr_acc && (s_write_addr == s_read_addr);
        end
    end

    kv_resp_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DATA_WIDTH + USER_WIDTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_data  ({rd_user_q, byp_q ? byp_data_q : rd_data_q}),
        .push       (rd_valid_q),
        .pop        (m_read_ready),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_kv_value_ram.sv
// Directed bench for kv_value_ram with a response scoreboard fed from the input handshakes.
module tb_kv_value_ram;

    typedef struct packed {
        logic [3:0]  user;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst;
    logic [31:0] s_write_data;
    logic [3:0]  s_write_addr;
    logic        s_write_valid;
    logic        s_write_ready;
    logic [3:0]  s_read_addr;
    logic [3:0]  s_read_user;
    logic        s_read_valid;
    logic        s_read_ready;
    logic [31:0] m_read_data;
    logic        m_read_valid;
    logic [3:0]  m_read_user;
    logic        m_read_ready;
    logic        init_busy;

    int          checks_total  = 0;
    int          checks_passed = 0;
    resp_t       sb[$];
    logic [31:0] model_mem [16];
    logic [3:0]  stall_addr [4];

    kv_value_ram #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (32),
        .USER_WIDTH (4),
        .OUT_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_write_data  (s_write_data),
        .s_write_addr  (s_write_addr),
        .s_write_valid (s_write_valid),
        .s_write_ready (s_write_ready),
        .s_read_addr   (s_read_addr),
        .s_read_user   (s_read_user),
        .s_read_valid  (s_read_valid),
        .s_read_ready  (s_read_ready),
        .m_read_data   (m_read_data),
        .m_read_valid  (m_read_valid),
        .m_read_user   (m_read_user),
        .m_read_ready  (m_read_ready),
        .init_busy     (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (init_busy && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'd16);
    endtask

    // Inputs are stable from negedge to the next posedge, so handshakes are judged here.
    always @(negedge clk) begin
        resp_t e;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < 16; i++) model_mem[i] = '0;
        end else begin
            if (m_read_valid && m_read_ready) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_data", 64'(m_read_data), 64'(e.data));
                    check("resp_user", 64'(m_read_user), 64'(e.user));
                end
            end
            if (s_read_valid && s_read_ready) begin
                e.user = s_read_user;
                e.data = (s_write_valid && s_write_ready && s_write_addr == s_read_addr)
                         ? s_write_data : model_mem[s_read_addr];
                sb.push_back(e);
            end
            if (s_write_valid && s_write_ready) model_mem[s_write_addr] = s_write_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        stall_addr[0] = 4'd5;
        stall_addr[1] = 4'd9;
        stall_addr[2] = 4'd2;
        stall_addr[3] = 4'd3;
        rst = 1'b1;
        s_write_data = '0;
        s_write_addr = '0;
        s_write_valid = 1'b0;
        s_read_addr = '0;
        s_read_user = '0;
        s_read_valid = 1'b0;
        m_read_ready = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        repeat (3) tick();

        check("rst_write_ready", 64'(s_write_ready), 64'd0);
        check("rst_read_ready", 64'(s_read_ready), 64'd0);
        check("rst_m_valid", 64'(m_read_valid), 64'd0);
        check("rst_m_data", 64'(m_read_data), 64'd0);
        check("rst_m_user", 64'(m_read_user), 64'd0);
        check("rst_init_busy", 64'(init_busy), 64'd1);

        rst = 1'b0;
        wait_init("init_cycles");
        check("run_write_ready", 64'(s_write_ready), 64'd1);
        check("run_read_ready", 64'(s_read_ready), 64'd1);

        // Streaming reads of every slot: cleared values, one response per cycle.
        for (int i = 0; i < 16; i++) begin
            s_read_valid = 1'b1;
            s_read_addr  = 4'(i);
            s_read_user  = 4'(i);
            check("stream_rd_ready", 64'(s_read_ready), 64'd1);
            check("stream_valid", 64'(m_read_valid), 64'(i >= 2));
            tick();
        end
        s_read_valid = 1'b0;
        check("stream_tail0", 64'(m_read_valid), 64'd1);
        tick();
        check("stream_tail1", 64'(m_read_valid), 64'd1);
        tick();
        check("stream_end", 64'(m_read_valid), 64'd0);

        // Write then read next cycle, latency 2.
        s_write_valid = 1'b1;
        s_write_addr  = 4'd5;
        s_write_data  = 32'hDEADBEEF;
        tick();
        s_write_valid = 1'b0;
        s_read_valid  = 1'b1;
        s_read_addr   = 4'd5;
        s_read_user   = 4'h3;
        check("lat_accept", 64'(s_read_ready), 64'd1);
        tick();
        s_read_valid = 1'b0;
        check("lat_n1_valid", 64'(m_read_valid), 64'd0);
        tick();
        check("lat_n2_valid", 64'(m_read_valid), 64'd1);
        check("lat_n2_data", 64'(m_read_data), 64'hDEADBEEF);
        check("lat_n2_user", 64'(m_read_user), 64'h3);
        tick();

        // Same-cycle collision is write-first; a write one cycle later is not seen.
        s_write_valid = 1'b1;
        s_write_addr  = 4'd9;
        s_write_data  = 32'h12345678;
        s_read_valid  = 1'b1;
        s_read_addr   = 4'd9;
        s_read_user   = 4'h4;
        tick();
        s_write_valid = 1'b0;
        s_read_user   = 4'h5;
        tick();
        s_read_valid  = 1'b0;
        s_write_valid = 1'b1;
        s_write_data  = 32'hAAAA0000;
        tick();
        s_write_valid = 1'b0;
        s_read_valid  = 1'b1;
        s_read_user   = 4'h6;
        tick();
        s_read_valid = 1'b0;
        repeat (4) tick();
        check("collision_drained", 64'(sb.size()), 64'd0);

        // Backpressure: credit limit, stable head during stall, prompt return of ready.
        m_read_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            s_read_valid = 1'b1;
            s_read_addr  = stall_addr[(n_acc < 4) ? n_acc : 3];
            s_read_user  = 4'(8 + n_acc);
            if (s_read_ready) n_acc++;
            tick();
        end
        s_read_valid = 1'b0;
        check("stall_accepts", 64'(n_acc), 64'd4);
        check("stall_rd_ready", 64'(s_read_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 64'(m_read_valid), 64'd1);
            check("stall_data", 64'(m_read_data), 64'hDEADBEEF);
            check("stall_user", 64'(m_read_user), 64'h8);
            tick();
        end
        m_read_ready = 1'b1;
        tick();
        check("rd_ready_after_pop", 64'(s_read_ready), 64'd1);
        repeat (5) tick();
        check("stall_drained", 64'(sb.size()), 64'd0);

        // Reset with three responses buffered.
        s_write_valid = 1'b1;
        s_write_addr  = 4'd2;
        s_write_data  = 32'h0BADF00D;
        tick();
        s_write_valid = 1'b0;
        m_read_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_read_valid = 1'b1;
            s_read_addr  = stall_addr[i];
            s_read_user  = 4'(10 + i);
            tick();
        end
        s_read_valid = 1'b0;
        tick();
        tick();
        check("buffered_valid", 64'(m_read_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", 64'(m_read_valid), 64'd0);
        check("post_rst_busy", 64'(init_busy), 64'd1);
        wait_init("reinit_cycles");
        m_read_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_read_valid = 1'b1;
            s_read_addr  = stall_addr[i];
            s_read_user  = 4'(i + 1);
            tick();
        end
        s_read_valid = 1'b0;
        repeat (5) tick();
        check("final_drained", 64'(sb.size()), 64'd0);
        check("final_valid", 64'(m_read_valid), 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
